// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: sequences imem requests under a credit limit, kills stale fetches on redirect,
// and buffers responses for the IF/ID handshake. Optional macro FETCH_MISALIGN_CHECK_EN halts on misaligned targets.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RSTN,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        JalrE,
  input  logic [31:0] JalrTarget,
  input  logic        JalD,
  input  logic [31:0] JalTarget,
  input  logic        StallF,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic        InstrValidF,
  output logic [31:0] InstrF,
  output logic [31:0] InstrPCF,
  input  logic        InstrReadyD,
  output logic [31:0] PCF,
  output logic        RedirectF,
  output logic        MisalignF
);
  localparam int unsigned   DEPTH = 4;
  localparam int unsigned   CW    = 3;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_OUTST);
  localparam logic [1:0]    LAST  = 2'(MAX_OUTST - 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state;

  logic [31:0]   pc;
  logic [CW-1:0] outst, kill, bcount, outst_nxt;
  logic [1:0]    a_wr, a_rd, b_wr, b_rd;
  logic [31:0]   a_pc   [DEPTH];
  logic [31:0]   b_data [DEPTH];
  logic [31:0]   b_pc   [DEPTH];

  logic        redirect, misalign, fire, resp, keep, pop;
  logic [31:0] target, load_pc;

  // Ring pointers wrap at MAX_OUTST so storage depth tracks the credit limit.
  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign PCF         = pc;
  assign ImemReqAddr = pc;
  assign InstrValidF = (bcount != '0);
  assign InstrF      = b_data[b_rd];
  assign InstrPCF    = b_pc[b_rd];

  always_comb begin
    redirect = (state != HALT) && (BranchE || JalrE || JalD);
    target   = BranchE ? BranchTarget : (JalrE ? JalrTarget : JalTarget);
`ifdef FETCH_MISALIGN_CHECK_EN
    load_pc  = target;
    misalign = redirect && (target[1:0] != 2'b00);
`else
    load_pc  = target & 32'hFFFF_FFFC;
    misalign = 1'b0;
`endif
    ImemReqValid = (state == RUN) && !StallF && !redirect && ((outst + bcount) < LIMIT);
    fire      = ImemReqValid && ImemReqReady;
    resp      = ImemRespValid && (outst != '0);
    keep      = resp && (kill == '0) && !redirect && (state == RUN);
    pop       = InstrValidF && InstrReadyD;
    outst_nxt = outst + CW'(fire) - CW'(resp);
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RSTN) begin
    if (!CPU_RSTN) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      outst     <= '0;
      kill      <= '0;
      bcount    <= '0;
      a_wr      <= '0;
      a_rd      <= '0;
      b_wr      <= '0;
      b_rd      <= '0;
      a_pc      <= '{default: '0};
      b_data    <= '{default: '0};
      b_pc      <= '{default: '0};
      RedirectF <= 1'b0;
      MisalignF <= 1'b0;
    end else begin
      RedirectF <= redirect;
      if (misalign) begin
        state     <= HALT;
        MisalignF <= 1'b1;
      end else if (state == BOOT) begin
        state <= RUN;
      end

      outst <= outst_nxt;
      if (fire) begin
        a_pc[a_wr] <= pc;
        a_wr       <= inc(a_wr);
      end
      if (resp) a_rd <= inc(a_rd);

      if (redirect)  pc <= load_pc;
      else if (fire) pc <= pc + 32'd4;

      // Everything still in flight after a redirect (or while halted) is stale.
      if (redirect || state == HALT)  kill <= outst_nxt;
      else if (resp && kill != '0)    kill <= kill - CW'(1);

      if (redirect) begin
        b_wr   <= '0;
        b_rd   <= '0;
        bcount <= '0;
      end else begin
        if (keep) begin
          b_data[b_wr] <= ImemRespData;
          b_pc[b_wr]   <= a_pc[a_rd];
          b_wr         <= inc(b_wr);
        end
        if (pop) b_rd <= inc(b_rd);
        bcount <= bcount + CW'(keep) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: in-order memory model returning ~addr with 1-cycle latency (holdable).
module tb_fetch_sequencer;
  logic        CPU_CLK = 1'b0;
  logic        CPU_RSTN = 1'b0;
  logic        BranchE = 1'b0, JalrE = 1'b0, JalD = 1'b0, StallF = 1'b0;
  logic [31:0] BranchTarget = '0, JalrTarget = '0, JalTarget = '0;
  logic        ImemReqValid, ImemReqReady = 1'b1;
  logic [31:0] ImemReqAddr;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = '0;
  logic        InstrValidF, InstrReadyD = 1'b1;
  logic [31:0] InstrF, InstrPCF, PCF;
  logic        RedirectF, MisalignF;

  int checks = 0;
  int errors = 0;

  logic        mem_hold = 1'b0;
  logic        fire_seen = 1'b0;
  logic [31:0] fire_addr = '0;
  logic [31:0] pend[$];
  logic [31:0] fire_q[$];
  logic [31:0] ipc_q[$];
  logic [31:0] idat_q[$];

  fetch_sequencer dut (
    .CPU_CLK(CPU_CLK), .CPU_RSTN(CPU_RSTN),
    .BranchE(BranchE), .BranchTarget(BranchTarget),
    .JalrE(JalrE), .JalrTarget(JalrTarget),
    .JalD(JalD), .JalTarget(JalTarget), .StallF(StallF),
    .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrValidF(InstrValidF), .InstrF(InstrF), .InstrPCF(InstrPCF), .InstrReadyD(InstrReadyD),
    .PCF(PCF), .RedirectF(RedirectF), .MisalignF(MisalignF)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Mid-cycle monitor: request fires and delivered instructions.
  always @(negedge CPU_CLK) begin
    fire_seen = ImemReqValid & ImemReqReady;
    fire_addr = ImemReqAddr;
    if (ImemReqValid === 1'b1 && ImemReqReady) fire_q.push_back(ImemReqAddr);
    if (InstrValidF === 1'b1 && InstrReadyD) begin
      ipc_q.push_back(InstrPCF);
      idat_q.push_back(InstrF);
    end
  end

  // In-order memory: a request fired before edge k answers in the cycle after edge k unless held.
  always @(posedge CPU_CLK) begin
    #2;
    if (!CPU_RSTN) begin
      pend.delete();
      ImemRespValid = 1'b0;
    end else begin
      if (fire_seen) pend.push_back(fire_addr);
      if (!mem_hold && pend.size() > 0) begin
        ImemRespValid = 1'b1;
        ImemRespData  = ~pend.pop_front();
      end else begin
        ImemRespValid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic do_reset();
    CPU_RSTN = 1'b0;
    BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0; StallF = 1'b0;
    ImemReqReady = 1'b1; InstrReadyD = 1'b1; mem_hold = 1'b0;
    repeat (2) @(posedge CPU_CLK);
    #1 CPU_RSTN = 1'b1;
    fire_q.delete(); ipc_q.delete(); idat_q.delete();
  endtask

  task automatic test_reset();
    CPU_RSTN = 1'b0;
    @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h want 00000000", PCF); end
    checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL reset_reqvalid: got %b want 0", ImemReqValid); end
    checks++; if ({InstrValidF, InstrF, InstrPCF} !== 65'h0) begin errors++; $display("FAIL reset_instr: got %b %h %h want 0", InstrValidF, InstrF, InstrPCF); end
    checks++; if ({RedirectF, MisalignF} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", RedirectF, MisalignF); end
  endtask

  task automatic test_fetch();
    int first;
    first = -1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge CPU_CLK);
      if (c == 0) begin
        checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b want 0", ImemReqValid); end
      end
      if (InstrValidF === 1'b1 && first < 0) first = c;
      next_cycle();
    end
    checks++; if (first != 3) begin errors++; $display("FAIL first_valid_cycle: got %0d want 3", first); end
    checks++; if (fire_q.size() < 3 || ipc_q.size() < 3) begin errors++; $display("FAIL fetch_count: got %0d/%0d want >=3", fire_q.size(), ipc_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (fire_q[k] !== 32'(4 * k)) begin errors++; $display("FAIL fetch_addr%0d: got %h want %h", k, fire_q[k], 32'(4 * k)); end
        checks++; if (ipc_q[k] !== 32'(4 * k) || idat_q[k] !== ~32'(4 * k)) begin errors++; $display("FAIL fetch_instr%0d: got %h/%h want %h", k, ipc_q[k], idat_q[k], 32'(4 * k)); end
      end
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    ImemReqReady = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      @(negedge CPU_CLK);
      checks++; if ({ImemReqValid, ImemReqAddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL hold_addr_c%0d: got %b %h want 1 00000000", c, ImemReqValid, ImemReqAddr); end
    end
    next_cycle();
    ImemReqReady = 1'b1;
    @(negedge CPU_CLK);
    next_cycle();
    @(negedge CPU_CLK);
    checks++; if ({ImemReqValid, ImemReqAddr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL after_ready_addr: got %b %h want 1 00000004", ImemReqValid, ImemReqAddr); end
  endtask

  task automatic test_backpressure();
    int extra;
    extra = 0;
    do_reset();
    InstrReadyD = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      @(negedge CPU_CLK);
      if (c >= 3 && ImemReqValid === 1'b1) extra++;
    end
    checks++; if (extra != 0 || fire_q.size() != 2) begin errors++; $display("FAIL credit_limit: got %0d extra, %0d fired want 0, 2", extra, fire_q.size()); end
    checks++; if ({InstrValidF, InstrPCF, InstrF} !== {1'b1, 32'h0, ~32'h0}) begin errors++; $display("FAIL held_head: got %b %h %h want 1 00000000 ffffffff", InstrValidF, InstrPCF, InstrF); end
    next_cycle();
    InstrReadyD = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CPU_CLK);
      next_cycle();
    end
    checks++; if (ipc_q.size() < 2) begin errors++; $display("FAIL release_count: got %0d want >=2", ipc_q.size()); end
    else begin
      checks++; if (ipc_q[0] !== 32'h0 || ipc_q[1] !== 32'h4) begin errors++; $display("FAIL release_order: got %h %h want 00000000 00000004", ipc_q[0], ipc_q[1]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_hold = 1'b1;
    repeat (3) next_cycle();
    @(negedge CPU_CLK);
    checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL two_in_flight_no_req: got %b want 0", ImemReqValid); end
    next_cycle();
    BranchE = 1'b1; BranchTarget = 32'h100; JalD = 1'b1; JalTarget = 32'h200; mem_hold = 1'b0;
    @(negedge CPU_CLK);
    checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL redirect_cycle_no_req: got %b want 0", ImemReqValid); end
    next_cycle();
    BranchE = 1'b0; JalD = 1'b0;
    fire_q.delete();
    @(negedge CPU_CLK);
    checks++; if ({RedirectF, PCF} !== {1'b1, 32'h100}) begin errors++; $display("FAIL redirect_pulse_pc: got %b %h want 1 00000100", RedirectF, PCF); end
    next_cycle();
    @(negedge CPU_CLK);
    checks++; if (RedirectF !== 1'b0) begin errors++; $display("FAIL redirect_one_cycle: got %b want 0", RedirectF); end
    repeat (6) next_cycle();
    checks++; if (fire_q.size() < 1 || ipc_q.size() < 1) begin errors++; $display("FAIL redirect_progress: got %0d/%0d want >=1", fire_q.size(), ipc_q.size()); end
    else begin
      checks++; if (fire_q[0] !== 32'h100) begin errors++; $display("FAIL redirect_req_addr: got %h want 00000100", fire_q[0]); end
      checks++; if (ipc_q[0] !== 32'h100 || idat_q[0] !== ~32'h100) begin errors++; $display("FAIL redirect_first_instr: got %h/%h want 00000100", ipc_q[0], idat_q[0]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    next_cycle();
    JalD = 1'b1; JalTarget = 32'hFFFF_FFFC;
    next_cycle();
    JalD = 1'b0;
    fire_q.delete(); ipc_q.delete(); idat_q.delete();
    repeat (8) next_cycle();
    checks++; if (fire_q.size() < 2 || ipc_q.size() < 2) begin errors++; $display("FAIL wrap_count: got %0d/%0d want >=2", fire_q.size(), ipc_q.size()); end
    else begin
      checks++; if (fire_q[0] !== 32'hFFFF_FFFC || fire_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", fire_q[0], fire_q[1]); end
      checks++; if (ipc_q[0] !== 32'hFFFF_FFFC || ipc_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_instr_pc: got %h %h want fffffffc 00000000", ipc_q[0], ipc_q[1]); end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    StallF = 1'b1;
    next_cycle();
    @(negedge CPU_CLK);
    checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL stall_no_req: got %b want 0", ImemReqValid); end
    next_cycle();
    BranchE = 1'b1; BranchTarget = 32'h40;
    next_cycle();
    BranchE = 1'b0;
    @(negedge CPU_CLK);
    checks++; if ({RedirectF, PCF, ImemReqValid} !== {1'b1, 32'h40, 1'b0}) begin errors++; $display("FAIL stall_redirect: got %b %h %b want 1 00000040 0", RedirectF, PCF, ImemReqValid); end
    next_cycle();
    StallF = 1'b0;
    @(negedge CPU_CLK);
    checks++; if ({ImemReqValid, ImemReqAddr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL unstall_req: got %b %h want 1 00000040", ImemReqValid, ImemReqAddr); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    mem_hold = 1'b1;
    repeat (3) next_cycle();
    CPU_RSTN = 1'b0;
    #1;
    checks++; if ({PCF, ImemReqValid, InstrValidF} !== {32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL midop_reset: got %h %b %b want 00000000 0 0", PCF, ImemReqValid, InstrValidF); end
    do_reset();
    repeat (6) next_cycle();
    checks++; if (ipc_q.size() < 1 || ipc_q[0] !== 32'h0) begin errors++; $display("FAIL post_reset_first_pc: got %0d entries want first 00000000", ipc_q.size()); end
  endtask

  task automatic test_misalign();
    int busy;
    busy = 0;
    do_reset();
    next_cycle();
    JalrE = 1'b1; JalrTarget = 32'h102; JalD = 1'b1; JalTarget = 32'h300;
    next_cycle();
    JalrE = 1'b0; JalD = 1'b0;
    fire_q.delete();
    @(negedge CPU_CLK);
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if ({MisalignF, PCF} !== {1'b1, 32'h102}) begin errors++; $display("FAIL misalign_flag: got %b %h want 1 00000102", MisalignF, PCF); end
    for (int c = 0; c < 8; c++) begin
      if (ImemReqValid === 1'b1 || InstrValidF === 1'b1) busy++;
      next_cycle();
      @(negedge CPU_CLK);
    end
    checks++; if (busy != 0 || MisalignF !== 1'b1) begin errors++; $display("FAIL halt_quiet: got %0d active cycles, flag %b want 0, 1", busy, MisalignF); end
    do_reset();
    @(negedge CPU_CLK);
    checks++; if (MisalignF !== 1'b0) begin errors++; $display("FAIL halt_reset_flag: got %b want 0", MisalignF); end
    next_cycle();
    @(negedge CPU_CLK);
    checks++; if ({ImemReqValid, ImemReqAddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL halt_exit_req: got %b %h want 1 00000000", ImemReqValid, ImemReqAddr); end
`else
    checks++; if ({RedirectF, MisalignF, PCF} !== {1'b1, 1'b0, 32'h100}) begin errors++; $display("FAIL align_force: got %b %b %h want 1 0 00000100", RedirectF, MisalignF, PCF); end
    repeat (3) next_cycle();
    if (MisalignF === 1'b1) busy++;
    checks++; if (busy != 0 || fire_q.size() < 1 || fire_q[0] !== 32'h100) begin errors++; $display("FAIL align_next_fetch: got %0d fires, misalign %0d want first 00000100", fire_q.size(), busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_req_stall();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_stall_redirect();
    test_reset_midop();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
